// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single waitrequest-style memory bus
// Define ARB_ROUND_ROBIN_EN to alternate priority under contention; default is fixed data priority.
module mem_arbiter #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_done,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_done,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [4:0] WAIT_LIMIT = 5'(MAX_WAIT);

  state_t      state, state_nxt;
  logic        op_write, op_write_nxt;
  logic [4:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] instr_hold, instr_hold_nxt;
  logic [31:0] data_hold, data_hold_nxt;
  logic        err_nxt;
  logic        data_pend;
  logic        timed_out;
  logic        pick_data;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_data, last_data_nxt;
`endif

  assign data_pend = data_read | data_write;
  assign timed_out = (wait_cnt == WAIT_LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_data = data_pend & (~instr_read | ~last_data);
`else
  assign pick_data = data_pend;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_write    <= 1'b0;
      wait_cnt    <= 5'd0;
      instr_hold  <= 32'd0;
      data_hold   <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      op_write    <= op_write_nxt;
      wait_cnt    <= wait_cnt_nxt;
      instr_hold  <= instr_hold_nxt;
      data_hold   <= data_hold_nxt;
      timeout_err <= err_nxt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_data <= 1'b0;
    else        last_data <= last_data_nxt;
  end
`endif

  // Strobes depend only on registered state (state, latched op, wait count),
  // so a request dropped mid-grant cannot glitch the memory bus.
  always_comb begin
    state_nxt      = state;
    op_write_nxt   = op_write;
    wait_cnt_nxt   = wait_cnt;
    instr_hold_nxt = instr_hold;
    data_hold_nxt  = data_hold;
    err_nxt        = timeout_err;
    mem_address    = 32'd0;
    mem_writedata  = 32'd0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    instr_done     = 1'b0;
    data_done      = 1'b0;
    instr_readdata = instr_hold;
    data_readdata  = data_hold;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_nxt  = last_data;
`endif

    case (state)
      IDLE: begin
        wait_cnt_nxt = 5'd0;
        if (pick_data) begin
          state_nxt    = GNT_D;
          op_write_nxt = data_write;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_nxt = 1'b1;
`endif
        end else if (instr_read) begin
          state_nxt = GNT_I;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_nxt = 1'b0;
`endif
        end
      end

      GNT_I: begin
        mem_address = instr_address;
        if (timed_out) begin
          instr_done     = 1'b1;
          instr_readdata = 32'd0;
          instr_hold_nxt = 32'd0;
          err_nxt        = 1'b1;
          state_nxt      = IDLE;
        end else begin
          mem_read = 1'b1;
          if (!mem_waitrequest) begin
            instr_done     = 1'b1;
            instr_readdata = mem_readdata;
            instr_hold_nxt = mem_readdata;
            state_nxt      = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt + 5'd1;
          end
        end
      end

      GNT_D: begin
        mem_address   = data_address;
        mem_writedata = data_writedata;
        if (timed_out) begin
          data_done     = 1'b1;
          data_readdata = 32'd0;
          data_hold_nxt = 32'd0;
          err_nxt       = 1'b1;
          state_nxt     = IDLE;
        end else begin
          mem_write = op_write;
          mem_read  = ~op_write;
          if (!mem_waitrequest) begin
            data_done     = 1'b1;
            data_readdata = mem_readdata;
            data_hold_nxt = mem_readdata;
            state_nxt     = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt + 5'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Honours ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_read = 1'b0;
  logic [31:0] instr_address = 32'd0;
  logic [31:0] instr_readdata;
  logic        instr_done;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_address = 32'd0;
  logic [31:0] data_writedata = 32'd0;
  logic [31:0] data_readdata;
  logic        data_done;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'd0;
  logic        mem_waitrequest = 1'b0;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_done(instr_done),
    .data_read(data_read), .data_write(data_write),
    .data_address(data_address), .data_writedata(data_writedata),
    .data_readdata(data_readdata), .data_done(data_done),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .timeout_err(timeout_err)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic exp_d;

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b0;
    #1;
    expect_eq("rst_mem_read",  32'(mem_read), 32'd0);
    expect_eq("rst_mem_write", 32'(mem_write), 32'd0);
    expect_eq("rst_i_done",    32'(instr_done), 32'd0);
    expect_eq("rst_d_done",    32'(data_done), 32'd0);
    expect_eq("rst_i_rdata",   instr_readdata, 32'd0);
    expect_eq("rst_d_rdata",   data_readdata, 32'd0);
    expect_eq("rst_err",       32'(timeout_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Lone fetch: IDLE cycle, then grant cycle completes immediately.
    instr_read = 1'b1; instr_address = 32'hBFC0_0000;
    mem_readdata = 32'h2402_0005; mem_waitrequest = 1'b0;
    @(negedge clk);
    expect_eq("fetch_c0_read", 32'(mem_read), 32'd0);
    expect_eq("fetch_c0_done", 32'(instr_done), 32'd0);
    next_cycle;
    @(negedge clk);
    expect_eq("fetch_c1_read", 32'(mem_read), 32'd1);
    expect_eq("fetch_c1_addr", mem_address, 32'hBFC0_0000);
    expect_eq("fetch_c1_done", 32'(instr_done), 32'd1);
    expect_eq("fetch_c1_rdata", instr_readdata, 32'h2402_0005);
    next_cycle;
    instr_read = 1'b0; mem_readdata = 32'h0;
    @(negedge clk);
    expect_eq("fetch_c2_read", 32'(mem_read), 32'd0);
    expect_eq("fetch_c2_done", 32'(instr_done), 32'd0);
    expect_eq("fetch_hold", instr_readdata, 32'h2402_0005);
    next_cycle;

    // Store with three stall cycles: mem_write held four cycles.
    data_write = 1'b1; data_address = 32'h1000; data_writedata = 32'hDEAD_BEEF;
    mem_waitrequest = 1'b1;
    next_cycle;
    for (int k = 1; k <= 4; k++) begin
      mem_waitrequest = (k < 4);
      @(negedge clk);
      expect_eq($sformatf("store_c%0d_wr", k), 32'(mem_write), 32'd1);
      expect_eq($sformatf("store_c%0d_rd", k), 32'(mem_read), 32'd0);
      expect_eq($sformatf("store_c%0d_done", k), 32'(data_done), (k == 4) ? 32'd1 : 32'd0);
      next_cycle;
    end
    data_write = 1'b0;
    @(negedge clk);
    expect_eq("store_after_wr", 32'(mem_write), 32'd0);
    expect_eq("store_wdata_idle", 32'(data_done), 32'd0);
    next_cycle;

    // Both data strobes: write wins.
    data_read = 1'b1; data_write = 1'b1; data_address = 32'h2000;
    data_writedata = 32'h1234_5678;
    next_cycle;
    @(negedge clk);
    expect_eq("both_wr", 32'(mem_write), 32'd1);
    expect_eq("both_rd", 32'(mem_read), 32'd0);
    expect_eq("both_addr", mem_address, 32'h2000);
    expect_eq("both_wdata", mem_writedata, 32'h1234_5678);
    expect_eq("both_done", 32'(data_done), 32'd1);
    next_cycle;
    data_read = 1'b0; data_write = 1'b0;
    next_cycle;

    // Timeout: strobe high 16 cycles, then dropped with done and zero data.
    data_read = 1'b1; data_address = 32'h3000; mem_waitrequest = 1'b1;
    mem_readdata = 32'h55AA_55AA;
    next_cycle;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      expect_eq($sformatf("tmo_c%0d_rd", k), 32'(mem_read), 32'd1);
      expect_eq($sformatf("tmo_c%0d_done", k), 32'(data_done), 32'd0);
      next_cycle;
    end
    @(negedge clk);
    expect_eq("tmo_drop_rd", 32'(mem_read), 32'd0);
    expect_eq("tmo_done", 32'(data_done), 32'd1);
    expect_eq("tmo_rdata", data_readdata, 32'd0);
    next_cycle;
    data_read = 1'b0; mem_waitrequest = 1'b0;
    @(negedge clk);
    expect_eq("tmo_err_set", 32'(timeout_err), 32'd1);
    expect_eq("tmo_idle_rd", 32'(mem_read), 32'd0);
    next_cycle;
    // A later good fetch leaves the sticky flag alone.
    instr_read = 1'b1; instr_address = 32'h40;
    next_cycle;
    @(negedge clk);
    expect_eq("sticky_fetch_done", 32'(instr_done), 32'd1);
    next_cycle;
    instr_read = 1'b0;
    @(negedge clk);
    expect_eq("tmo_err_sticky", 32'(timeout_err), 32'd1);
    next_cycle;

    // Reset in the second stall cycle of a load.
    data_read = 1'b1; data_address = 32'h4000; mem_waitrequest = 1'b1;
    next_cycle;
    next_cycle;
    @(negedge clk);
    expect_eq("rmid_rd_before", 32'(mem_read), 32'd1);
    #2 reset = 1'b0;
    #1;
    expect_eq("rmid_rd_async", 32'(mem_read), 32'd0);
    expect_eq("rmid_no_done", 32'(data_done), 32'd0);
    expect_eq("rmid_err_clr", 32'(timeout_err), 32'd0);
    mem_waitrequest = 1'b0;
    #1;
    expect_eq("rmid_no_done_wr0", 32'(data_done), 32'd0);
    data_read = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    // First grant decision on the first edge after release.
    instr_read = 1'b1; instr_address = 32'h80;
    @(negedge clk);
    expect_eq("rmid_idle_rd", 32'(mem_read), 32'd0);
    next_cycle;
    @(negedge clk);
    expect_eq("post_rst_grant", 32'(instr_done), 32'd1);
    next_cycle;
    instr_read = 1'b0;

    // Contention from a fresh reset so the last-grant flag starts at instruction.
    do_reset;
    instr_read = 1'b1; data_read = 1'b1; instr_address = 32'h100;
    data_address = 32'h200; mem_waitrequest = 1'b0; mem_readdata = 32'hCAFE_0000;
    for (int r = 0; r < 10; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (r % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      @(negedge clk);
      expect_eq($sformatf("cont%0d_idle_rd", r), 32'(mem_read), 32'd0);
      next_cycle;
      @(negedge clk);
      expect_eq($sformatf("cont%0d_d_done", r), 32'(data_done), 32'(exp_d));
      expect_eq($sformatf("cont%0d_i_done", r), 32'(instr_done), 32'(!exp_d));
      next_cycle;
    end
    instr_read = 1'b0; data_read = 1'b0;
    next_cycle;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, the number of consecutive cycles of waitrequest tolerated before a transfer is aborted.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr_read  input  1  fetch request, held high until instr_done.
REQ-005 SHALL have port instr_address  input  32  fetch byte address.
REQ-006 SHALL have port instr_readdata  output  32  fetched word.
REQ-007 SHALL have port instr_done  output  1  one-cycle pulse marking fetch completion.
REQ-008 SHALL have port data_read  input  1  load request, held high until data_done.
REQ-009 SHALL have port data_write  input  1  store request, held high until data_done.
REQ-010 SHALL have port data_address  input  32  load/store byte address.
REQ-011 SHALL have port data_writedata  input  32  store data.
REQ-012 SHALL have port data_readdata  output  32  loaded word.
REQ-013 SHALL have port data_done  output  1  one-cycle pulse marking load/store completion.
REQ-014 SHALL have port mem_address  output  32  shared memory address.
REQ-015 SHALL have port mem_read  output  1  shared memory read strobe.
REQ-016 SHALL have port mem_write  output  1  shared memory write strobe.
REQ-017 SHALL have port mem_writedata  output  32  shared memory write data.
REQ-018 SHALL have port mem_readdata  input  32  shared memory read data, valid in the cycle waitrequest is low.
REQ-019 SHALL have port mem_waitrequest  input  1  memory stall; a transfer completes on an edge where the strobe is high and waitrequest is low.
REQ-020 SHALL have port timeout_err  output  1  sticky error flag for an aborted transfer.

Function
REQ-021 SHALL implement a three-state FSM: IDLE, GNT_I and GNT_D.
REQ-022 In IDLE, all memory strobes SHALL be low; on the next edge the FSM SHALL move to GNT_D if a data request is pending, else to GNT_I if instr_read is high, else stay in IDLE.
REQ-023 In GNT_I, the block SHALL drive mem_read=1 and mem_address=instr_address.
REQ-024 In GNT_D, the block SHALL drive mem_address=data_address and mem_writedata=data_writedata.
REQ-025 In GNT_D, the block SHALL drive mem_write=data_write and mem_read=data_read&~data_write; when both requests are high, the write wins.
REQ-026 The memory strobes SHALL be decoded from state only, with no combinational path from any request input to mem_read or mem_write.
REQ-027 In a granted state with mem_waitrequest=0, the block SHALL pulse the granted requester's done high in that same cycle and pass mem_readdata through to its readdata.
REQ-028 On the completion edge of REQ-027, readdata SHALL also be captured into a hold register and the FSM SHALL return to IDLE.
REQ-029 Outside the completion cycle, instr_readdata and data_readdata SHALL show their last captured value.
REQ-030 Latency SHALL be at least 2 cycles from request to done (one IDLE cycle plus one grant cycle), plus one cycle per waitrequest cycle.
REQ-031 Back-to-back transfers SHALL always pass through one IDLE cycle, and at most one requester SHALL be granted at any time.
REQ-032 A request dropped while granted is a protocol violation; the FSM SHALL still complete the current memory transfer, with done pulsed and ignored.
REQ-033 A 5-bit wait counter SHALL clear on entry to a granted state and increment each granted cycle with waitrequest=1.
REQ-034 When the wait counter reaches MAX_WAIT, the block SHALL drop the strobes, pulse done with readdata=0, set timeout_err and return to IDLE.
REQ-035 timeout_err SHALL be cleared only by reset.

Reset
REQ-036 While reset=0, the block SHALL immediately and asynchronously force state IDLE, mem_read=0, mem_write=0, both done=0, both hold registers=0, the wait counter=0 and timeout_err=0.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer with no done pulse.
REQ-038 After reset is released, the first grant decision SHALL be made on the first clk edge.

Configuration
REQ-039 SHALL support macro ARB_ROUND_ROBIN_EN.
REQ-040 Without ARB_ROUND_ROBIN_EN, data SHALL always have fixed priority over instruction when both are pending in IDLE.
REQ-041 With ARB_ROUND_ROBIN_EN, a last-grant flag (reset value: instruction) SHALL give priority, when both are pending in IDLE, to the requester not granted last; a lone request SHALL be granted regardless of the flag.

Verification
REQ-042 Scenario, lone fetch: instr_read=1, address 0xBFC00000, waitrequest=0, readdata 0x24020005 -> mem_read high in cycle 1, instr_done pulses in cycle 1, instr_readdata=0x24020005.
REQ-043 Scenario, store with stall: data_write=1, address 0x1000, data 0xDEADBEEF, waitrequest high for 3 cycles -> mem_write held for 4 cycles, data_done pulses in the 4th.
REQ-044 Scenario, contention: instr_read and data_read asserted in the same cycle, 10 back-to-back rounds -> without the macro, data is granted every round; with the macro, grants alternate D,I,D,I...
REQ-045 Scenario, timeout: waitrequest held at 1 with MAX_WAIT=16 -> strobe drops after 16 cycles, done pulses with readdata=0, timeout_err=1 until reset.
REQ-046 Scenario, reset mid-grant: reset pulled low in the 2nd stall cycle of a load -> mem_read falls before the next clk edge, no data_done, FSM in IDLE.
REQ-047 Scenario, both data strobes: data_read=1 and data_write=1 together -> mem_write=1 and mem_read=0.
